// File: rtl/adc_arb_pkg.sv
// Shared types and constants for the ADC arbiter: FSM encoding, widths, channel indices
// and the saturating counter helper.
package adc_arb_pkg;

    localparam int unsigned TAG_W  = 2;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 8;

    localparam logic [TAG_W-1:0] CH_VOUT   = 2'd0;
    localparam logic [TAG_W-1:0] CH_ISENSE = 2'd1;
    localparam logic [TAG_W-1:0] CH_TEMP   = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StConv,
        StWaitH,
        StWaitL,
        StRead
    } state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin index search over req, starting one past the registered pointer, with wrap.
// The pointer takes the winning index whenever the caller loads a grant.
module rr_arbiter
    import adc_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               load_i,
    output logic               valid_o,
    output logic [TAG_W-1:0]   idx_o
);

    logic [TAG_W-1:0] ptr_q;
    logic [3:0]       req_ext;
    logic [TAG_W:0]   sum;

    always_comb begin
        req_ext = 4'(req_i);
        valid_o = 1'b0;
        idx_o   = '0;
        sum     = '0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            sum = {1'b0, ptr_q} + (TAG_W+1)'(k);
            if (sum >= (TAG_W+1)'(NUM_REQ)) begin
                sum = sum - (TAG_W+1)'(NUM_REQ);
            end
            if (!valid_o && req_ext[sum[TAG_W-1:0]]) begin
                valid_o = 1'b1;
                idx_o   = sum[TAG_W-1:0];
            end
        end
    end

    // Reset to the last index so requester 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= TAG_W'(NUM_REQ - 1);
        end else if (load_i) begin
            ptr_q <= idx_o;
        end
    end

endmodule

// File: rtl/adc_arbiter.sv
// Shares one parallel ADC between requesters: arbitration, mux settling, CONVST/BUSY/RD-CS
// handshake and tagged sample delivery. Define ADC_ARB_TIMEOUT_EN for the busy watchdog.
module adc_arbiter
    import adc_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 3,
    parameter int unsigned MUX_SETTLE   = 4,
    parameter int unsigned CONV_PULSE   = 10,
    parameter int unsigned RD_PULSE     = 10,
    parameter int unsigned BUSY_TIMEOUT = 200
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic               data_valid,
    output logic [DATA_W-1:0]  data_out,
    output logic [TAG_W-1:0]   data_tag,
    output logic [TAG_W-1:0]   mux_sel,
    output logic               convStart,
    output logic               rd_cs,
    input  logic               busy,
    input  logic [DATA_W-1:0]  adcVoltage,
    output logic               timeout_err
);

`ifdef ADC_ARB_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    localparam logic [CNT_W-1:0] SettleLast = CNT_W'(MUX_SETTLE) - CNT_W'(1);
    localparam logic [CNT_W-1:0] ConvLast   = CNT_W'(CONV_PULSE) - CNT_W'(1);
    localparam logic [CNT_W-1:0] RdLast     = CNT_W'(RD_PULSE) - CNT_W'(1);
    localparam logic [CNT_W-1:0] BusyLast   = CNT_W'(BUSY_TIMEOUT) - CNT_W'(1);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [NUM_REQ-1:0]  grant_q;
    logic [TAG_W-1:0]    mux_sel_q;
    logic [TAG_W-1:0]    tag_q;
    logic [DATA_W-1:0]   data_q;
    logic                conv_q;
    logic                rd_cs_q;
    logic                dv_q;
    logic                to_q;
    logic                busy_meta_q;
    logic                busy_s_q;
    logic                arb_valid;
    logic [TAG_W-1:0]    arb_idx;
    logic                arb_load;
    logic                wd_expired;

    assign arb_load   = (state_q == StIdle) && arb_valid;
    assign wd_expired = TimeoutEn && (cnt_q >= BusyLast);

    rr_arbiter #(
        .NUM_REQ(NUM_REQ)
    ) u_rr (
        .clk    (clk),
        .reset  (reset),
        .req_i  (req),
        .load_i (arb_load),
        .valid_o(arb_valid),
        .idx_o  (arb_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_meta_q <= 1'b0;
            busy_s_q    <= 1'b0;
        end else begin
            busy_meta_q <= busy;
            busy_s_q    <= busy_meta_q;
        end
    end

    // mux_sel_q doubles as the tag of the transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            grant_q   <= '0;
            mux_sel_q <= '0;
            tag_q     <= '0;
            data_q    <= '0;
            conv_q    <= 1'b0;
            rd_cs_q   <= 1'b1;
            dv_q      <= 1'b0;
            to_q      <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            to_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (arb_valid) begin
                        grant_q   <= NUM_REQ'(1) << arb_idx;
                        mux_sel_q <= arb_idx;
                        cnt_q     <= '0;
                        state_q   <= (MUX_SETTLE == 0) ? StConv : StSettle;
                    end
                end
                StSettle: begin
                    if (cnt_q >= SettleLast) begin
                        cnt_q   <= '0;
                        state_q <= StConv;
                    end else begin
                        cnt_q <= sat_inc(cnt_q);
                    end
                end
                StConv: begin
                    if (!conv_q) begin
                        conv_q <= 1'b1;
                        cnt_q  <= '0;
                    end else if (cnt_q >= ConvLast) begin
                        conv_q  <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StWaitH;
                    end else begin
                        cnt_q <= sat_inc(cnt_q);
                    end
                end
                StWaitH, StWaitL: begin
                    // Watchdog count spans both busy phases; cleared only on CONV exit.
                    cnt_q <= sat_inc(cnt_q);
                    if ((state_q == StWaitH) && busy_s_q) begin
                        state_q <= StWaitL;
                    end else if ((state_q == StWaitL) && !busy_s_q) begin
                        rd_cs_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= StRead;
                    end else if (wd_expired) begin
                        to_q    <= 1'b1;
                        grant_q <= '0;
                        state_q <= StIdle;
                    end
                end
                StRead: begin
                    if (cnt_q >= RdLast) begin
                        data_q  <= adcVoltage;
                        tag_q   <= mux_sel_q;
                        dv_q    <= 1'b1;
                        rd_cs_q <= 1'b1;
                        grant_q <= '0;
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= sat_inc(cnt_q);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign grant       = grant_q;
    assign mux_sel     = mux_sel_q;
    assign data_out    = data_q;
    assign data_tag    = tag_q;
    assign data_valid  = dv_q;
    assign convStart   = conv_q;
    assign rd_cs       = rd_cs_q;
    assign timeout_err = to_q;

endmodule

// File: tb/tb_adc_arbiter.sv
// Bench for adc_arbiter: ADC/analog-mux model, sample scoreboard, one task per scenario.
module tb_adc_arbiter;
    import adc_arb_pkg::*;

    localparam int unsigned NR = 3;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } sb_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NR-1:0] req = '0;
    logic [NR-1:0] req_ns = '0;
    logic          busy = 1'b0;
    logic          busy_ns = 1'b0;
    logic [7:0]    adc_v;
    logic [7:0]    adc_ns = 8'h00;
    logic [7:0]    chan_volt [4];

    logic [NR-1:0] grant, grant_ns;
    logic          data_valid, dv_ns;
    logic [7:0]    data_out, data_ns;
    logic [1:0]    data_tag, tag_ns, mux_sel, mux_ns;
    logic          conv_start, conv_ns, rd_cs, rd_ns, timeout_err, to_ns;

    int   checks = 0;
    int   errors = 0;
    int   dv_count = 0;
    sb_t  sb_q[$];
    sb_t  sb_exp;
    bit   adc_en = 1'b1;
    logic conv_prev = 1'b0;
    int   adc_t = 0;

    always #5 clk = ~clk;

    // Analog mux: each channel presents a distinct voltage.
    assign adc_v = chan_volt[mux_sel];

    adc_arbiter #(
        .NUM_REQ(NR), .MUX_SETTLE(4), .CONV_PULSE(10), .RD_PULSE(10), .BUSY_TIMEOUT(200)
    ) u_dut (
        .clk(clk), .reset(reset), .req(req), .grant(grant), .data_valid(data_valid),
        .data_out(data_out), .data_tag(data_tag), .mux_sel(mux_sel), .convStart(conv_start),
        .rd_cs(rd_cs), .busy(busy), .adcVoltage(adc_v), .timeout_err(timeout_err)
    );

    adc_arbiter #(
        .NUM_REQ(NR), .MUX_SETTLE(0), .CONV_PULSE(10), .RD_PULSE(10), .BUSY_TIMEOUT(200)
    ) u_dut_ns (
        .clk(clk), .reset(reset), .req(req_ns), .grant(grant_ns), .data_valid(dv_ns),
        .data_out(data_ns), .data_tag(tag_ns), .mux_sel(mux_ns), .convStart(conv_ns),
        .rd_cs(rd_ns), .busy(busy_ns), .adcVoltage(adc_ns), .timeout_err(to_ns)
    );

    // ADC: busy rises 3 cycles after convStart falls and stays high 20 cycles.
    always @(posedge clk) begin
        if (reset) begin
            busy      <= 1'b0;
            adc_t     <= 0;
            conv_prev <= 1'b0;
        end else begin
            conv_prev <= conv_start;
            if (adc_en && conv_prev && !conv_start) adc_t <= 1;
            else if (adc_t != 0) adc_t <= adc_t + 1;
            if (adc_t == 2) busy <= 1'b1;
            if (adc_t == 22) begin
                busy  <= 1'b0;
                adc_t <= 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && data_valid) begin
            dv_count++;
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got tag=%0d data=%h, required no sample",
                         data_tag, data_out);
            end else begin
                sb_exp = sb_q.pop_front();
                if (data_tag !== sb_exp.tag || data_out !== sb_exp.data) begin
                    errors++;
                    $display("FAIL sb_sample got tag=%0d data=%h, required tag=%0d data=%h",
                             data_tag, data_out, sb_exp.tag, sb_exp.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1);
    end

    function automatic sb_t mk(input logic [1:0] t);
        sb_t s;
        s.tag  = t;
        s.data = chan_volt[t];
        return s;
    endfunction

    task automatic do_reset();
        req    = '0;
        req_ns = '0;
        reset  = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic watch(input int drop_mode, input int max_cyc, output int t_g, output int t_c,
                         output int conv_w, output int rd_w, output bit done);
        t_g = -1; t_c = -1; conv_w = 0; rd_w = 0; done = 1'b0;
        for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
            @(negedge clk);
            if (grant != 0 && t_g < 0) begin
                t_g = cyc;
                if (drop_mode == 0) req = '0;
            end
            if (conv_start) begin
                if (t_c < 0) t_c = cyc;
                conv_w++;
                if (drop_mode == 1) req = '0;
            end
            if (!rd_cs) rd_w++;
            if (data_valid) done = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({grant, data_valid, timeout_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl got grant=%b dv=%b to=%b, required 0", grant, data_valid,
                     timeout_err);
        end
        checks++;
        if ({conv_start, rd_cs} !== 2'b01) begin
            errors++;
            $display("FAIL reset_adc got conv=%b rd_cs=%b, required 0 1", conv_start, rd_cs);
        end
        checks++;
        if ({data_out, data_tag, mux_sel} !== 12'h0) begin
            errors++;
            $display("FAIL reset_data got data=%h tag=%0d mux=%0d, required 0", data_out,
                     data_tag, mux_sel);
        end
        checks++;
        if ({grant_ns, dv_ns, data_ns, tag_ns, mux_ns, conv_ns, rd_ns, to_ns} !== 20'h2) begin
            errors++;
            $display("FAIL reset_ns got %b, required only rd_cs high",
                     {grant_ns, dv_ns, data_ns, tag_ns, mux_ns, conv_ns, rd_ns, to_ns});
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        int tg, tc, cw, rw, dv0;
        bit done;
        do_reset();
        dv0 = dv_count;
        sb_q.push_back(mk(CH_VOUT));
        req = 3'b001;
        watch(0, 300, tg, tc, cw, rw, done);
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL single_done got no data_valid within 300 cycles, required one");
        end
        checks++;
        if (tc - tg !== 5) begin
            errors++;
            $display("FAIL single_conv_delay got %0d, required 5", tc - tg);
        end
        checks++;
        if (cw !== 10) begin
            errors++;
            $display("FAIL single_conv_width got %0d, required 10", cw);
        end
        checks++;
        if (rw !== 10) begin
            errors++;
            $display("FAIL single_rd_width got %0d, required 10", rw);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (dv_count - dv0 !== 1) begin
            errors++;
            $display("FAIL single_dv_count got %0d, required 1", dv_count - dv0);
        end
    endtask

    task automatic test_rotation();
        int order [6] = '{0, 1, 2, 0, 1, 2};
        int n_dv = 0;
        int cyc = 0;
        bit chk_next = 1'b0;
        bit first = 1'b1;
        logic [NR-1:0] exp_g;
        do_reset();
        for (int i = 0; i < 6; i++) sb_q.push_back(mk(2'(order[i])));
        req = 3'b111;
        while (n_dv < 6 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (first && grant != 0) begin
                first = 1'b0;
                exp_g = 3'(1) << order[0];
                checks++;
                if (grant !== exp_g) begin
                    errors++;
                    $display("FAIL rr_first got grant=%b, required %b", grant, exp_g);
                end
            end
            if (chk_next) begin
                chk_next = 1'b0;
                exp_g = 3'(1) << order[n_dv];
                checks++;
                if (grant !== exp_g) begin
                    errors++;
                    $display("FAIL rr_next_%0d got grant=%b, required %b", n_dv, grant, exp_g);
                end
            end
            if (data_valid) begin
                n_dv++;
                if (n_dv < 6) chk_next = 1'b1;
                else req = '0;
            end
        end
        checks++;
        if (n_dv != 6) begin
            errors++;
            $display("FAIL rr_count got %0d samples, required 6", n_dv);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_drop();
        int tg, tc, cw, rw, dv0;
        bit done;
        do_reset();
        dv0 = dv_count;
        sb_q.push_back(mk(CH_ISENSE));
        req = 3'b010;
        watch(1, 300, tg, tc, cw, rw, done);
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL drop_done got no data_valid within 300 cycles, required one");
        end
        repeat (30) @(negedge clk);
        checks++;
        if (dv_count - dv0 !== 1) begin
            errors++;
            $display("FAIL drop_dv_count got %0d, required 1", dv_count - dv0);
        end
    endtask

    task automatic test_reset_mid();
        int dv0;
        bit found = 1'b0;
        do_reset();
        dv0 = dv_count;
        req = 3'b001;
        for (int c = 0; c < 300 && !found; c++) begin
            @(negedge clk);
            if (!rd_cs) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rstmid_read got no READ phase within 300 cycles, required one");
        end
        req   = '0;
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({rd_cs, grant, conv_start, data_valid} !== 6'b100000) begin
            errors++;
            $display("FAIL rstmid_outputs got rd_cs=%b grant=%b conv=%b dv=%b, required 1 000 0 0",
                     rd_cs, grant, conv_start, data_valid);
        end
        reset = 1'b0;
        repeat (40) @(negedge clk);
        checks++;
        if (dv_count !== dv0 || grant !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_after got dv=%0d grant=%b, required dv=0 grant=000",
                     dv_count - dv0, grant);
        end
    endtask

`ifdef ADC_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int dv0, t_fall, t_to;
        bit seen_conv = 1'b0;
        bit rd_ok = 1'b1;
        logic [NR-1:0] g_to;
        logic [7:0] d_before;
        do_reset();
        adc_en   = 1'b0;
        dv0      = dv_count;
        d_before = data_out;
        t_fall   = -1;
        t_to     = -1;
        g_to     = 'x;
        req      = 3'b011;
        for (int c = 0; c < 600 && t_to < 0; c++) begin
            @(negedge clk);
            if (conv_start) seen_conv = 1'b1;
            else if (seen_conv && t_fall < 0) t_fall = c;
            if (!rd_cs) rd_ok = 1'b0;
            if (timeout_err) begin
                t_to = c;
                g_to = grant;
            end
        end
        checks++;
        if (t_to < 0 || t_to - t_fall !== 200) begin
            errors++;
            $display("FAIL to_delay got %0d, required 200", t_to - t_fall);
        end
        checks++;
        if (g_to !== 3'b000) begin
            errors++;
            $display("FAIL to_grant got %b, required 000", g_to);
        end
        @(negedge clk);
        checks++;
        if (grant !== 3'b010 || timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL to_next got grant=%b to=%b, required 010 0", grant, timeout_err);
        end
        req = '0;
        checks++;
        if (dv_count !== dv0 || data_out !== d_before || !rd_ok) begin
            errors++;
            $display("FAIL to_side got dv=%0d data=%h rd_ok=%b, required 0 %h 1",
                     dv_count - dv0, data_out, rd_ok, d_before);
        end
        adc_en = 1'b1;
    endtask
`else
    task automatic test_timeout();
        int dv0;
        bit to_seen = 1'b0;
        do_reset();
        adc_en = 1'b0;
        dv0    = dv_count;
        req    = 3'b001;
        repeat (300) begin
            @(negedge clk);
            if (timeout_err) to_seen = 1'b1;
        end
        checks++;
        if (to_seen || grant !== 3'b001 || dv_count !== dv0) begin
            errors++;
            $display("FAIL nowd_wait got to=%b grant=%b dv=%0d, required 0 001 0", to_seen,
                     grant, dv_count - dv0);
        end
        req    = '0;
        adc_en = 1'b1;
    endtask
`endif

    task automatic test_no_settle();
        int tg = -1;
        int tc = -1;
        int cw = 0;
        do_reset();
        req_ns = 3'b001;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (grant_ns != 0 && tg < 0) begin
                tg = c;
                req_ns = '0;
            end
            if (conv_ns) begin
                if (tc < 0) tc = c;
                cw++;
            end
        end
        checks++;
        if (tg < 0 || tc - tg !== 1) begin
            errors++;
            $display("FAIL nosettle_delay got %0d, required 1", tc - tg);
        end
        checks++;
        if (cw !== 10) begin
            errors++;
            $display("FAIL nosettle_width got %0d, required 10", cw);
        end
    endtask

    initial begin
        chan_volt[0] = 8'hA5;
        chan_volt[1] = 8'h3C;
        chan_volt[2] = 8'h5A;
        chan_volt[3] = 8'h00;
        test_reset();
        test_single();
        test_rotation();
        test_drop();
        test_reset_mid();
        test_timeout();
        test_no_settle();
        do_reset();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d pending samples, required 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
